// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the 3-wire SPI register target:
//               header field positions, frame lengths, bit-counter constants
//               and the frame-decoder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Frame geometry: 16-bit instruction header followed by one data byte.
  localparam int c_hdr_bits   = 16;
  localparam int c_data_bits  = 8;
  localparam int c_frame_bits = c_hdr_bits + c_data_bits;

  // Header field positions.
  localparam int c_rw_bit   = 15;  // 1 = read, 0 = write
  localparam int c_w1_bit   = 14;  // byte-count bits, accepted but ignored
  localparam int c_w0_bit   = 13;
  localparam int c_ahi_msb  = 12;  // A12:A8 must be zero for a legal frame
  localparam int c_ahi_lsb  = 8;
  localparam int c_addr_msb = 7;   // A7:A0 select the register

  // Bit counter sized to hold the longest phase (header).
  localparam int                 c_cnt_w     = 5;
  localparam logic [c_cnt_w-1:0] c_hdr_last  = c_cnt_w'(c_hdr_bits - 1);
  localparam logic [c_cnt_w-1:0] c_data_last = c_cnt_w'(c_data_bits - 1);
  localparam logic [c_cnt_w-1:0] c_data_done = c_cnt_w'(c_data_bits);

  // Frame decoder states, explicitly encoded.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_WDATA   = 3'd2,
    ST_RDATA   = 3'd3,
    ST_WAIT_CS = 3'd4
  } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_target_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_target_sync
// Description : Two-flop synchroniser for one asynchronous input, followed by
//               a history flop so rising/falling edges of the synchronised
//               level can be flagged for one clk cycle.
// Ports       : clk, reset      - system clock, synchronous active-high reset
//               async_in        - asynchronous input
//               sync_out        - synchronised level
//               rise / fall     - one-cycle edge flags of sync_out
// Revision    : 1.0 - initial release
// ============================================================================
module spi_target_sync
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // History flop resets to the same value as the chain so no edge is
  // reported while reset is being released.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign sync_out = r_sync;
  assign rise     =  r_sync & ~r_prev;
  assign fall     = ~r_sync &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_adc_target.sv
`default_nettype none
// ============================================================================
// Module      : spi_adc_target
// Description : 3-wire SPI register target (ADC-style framing). A frame is a
//               16-bit header (r/wb, w1, w0, A12:A8, A7:A0) followed by one
//               data byte. Writes land in a 256 x 8 register file; reads
//               return the addressed byte on the shared sdio line. All SPI
//               pins are oversampled in the clk domain.
// Ports       : clk, reset            - system clock, sync active-high reset
//               sclk, csb             - SPI clock / active-low chip select
//               sdio                  - bidirectional serial data
//               reg_addr / reg_rdata  - local read port, 1-cycle latency
//               wr_strobe, wr_addr,
//               wr_data               - pulse per completed SPI write
//               frame_err             - pulse on aborted or illegal frame
//               busy                  - high outside IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module spi_adc_target
  import spi_pkg::*;
#(
  parameter int CLK_DIV_MIN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       csb,
  inout  wire        sdio,
  input  logic [7:0] reg_addr,
  output logic [7:0] reg_rdata,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic       busy
);

  // Edges are seen roughly three clk cycles after the pin moves, so each
  // sclk half-period must span several clk cycles. Below a ratio of 6 a
  // half-period can be lost; nothing is built for that case.
  if (CLK_DIV_MIN < 6) begin : g_clk_div_below_margin
  end

  // --------------------------------------------------------------------------
  // Input synchronisation
  // --------------------------------------------------------------------------
  logic w_sclk_s;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_csb_s;
  logic w_csb_rise;
  logic w_csb_fall;

  spi_target_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk      (clk),
    .reset    (reset),
    .async_in (sclk),
    .sync_out (w_sclk_s),
    .rise     (w_sclk_rise),
    .fall     (w_sclk_fall)
  );

  spi_target_sync #(.RESET_VAL(1'b1)) u_sync_csb (
    .clk      (clk),
    .reset    (reset),
    .async_in (csb),
    .sync_out (w_csb_s),
    .rise     (w_csb_rise),
    .fall     (w_csb_fall)
  );

  // Data only needs its level, so it gets a plain two-flop chain.
  logic r_sdi_meta;
  logic r_sdi;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sdi_meta <= 1'b0;
      r_sdi      <= 1'b0;
    end else begin
      r_sdi_meta <= sdio;
      r_sdi      <= r_sdi_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Frame decoder state
  // --------------------------------------------------------------------------
  spi_state_t          r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  // Holds the first 15 header bits; the 16th comes straight from the
  // synchroniser in the cycle the header is decoded.
  logic [c_hdr_bits-2:0] r_shift;
  logic [7:0]          r_addr;
  logic [7:0]          r_tx;
  logic                r_sdo;
  logic                r_oe;
  logic                r_wr_strobe;
  logic [7:0]          r_wr_addr;
  logic [7:0]          r_wr_data;
  logic                r_frame_err;
  logic [1:0]          r_settle;

  logic [7:0]          r_regfile [256];
  logic [7:0]          r_rdata;

  logic [c_hdr_bits-1:0] w_shift_next;
  logic                  w_wr_en;
  logic                  w_frame_open;
  logic                  w_sync_ready;

  assign w_shift_next = {r_shift, r_sdi};

  // Final data bit of a write, not pre-empted by chip-select release.
  assign w_wr_en = (r_state == ST_WDATA) && w_sclk_rise && !w_csb_rise &&
                   (r_cnt == c_data_last);

  // A read counts as complete once all eight bits have been driven.
  assign w_frame_open = (r_state == ST_HEADER) || (r_state == ST_WDATA) ||
                        ((r_state == ST_RDATA) && (r_cnt != c_data_done));

  // The csb chain reports its reset value (high) for two cycles after reset
  // releases; WAIT_CS must not trust the level until the real pin value has
  // propagated, or a frame in progress would be accepted mid-way.
  assign w_sync_ready = (r_settle == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_WAIT_CS;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_addr      <= 8'h00;
      r_tx        <= 8'h00;
      r_sdo       <= 1'b0;
      r_oe        <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 8'h00;
      r_wr_data   <= 8'h00;
      r_frame_err <= 1'b0;
      r_settle    <= 2'd0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      if (!w_sync_ready) begin
        r_settle <= r_settle + 2'd1;
      end

      // Chip-select release overrides any sclk activity in the same cycle.
      // WAIT_CS handles release through its own level check below.
      if (w_csb_rise && (r_state != ST_WAIT_CS)) begin
        r_oe    <= 1'b0;
        r_state <= ST_IDLE;
        if (w_frame_open) begin
          r_frame_err <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_oe <= 1'b0;
            if (w_csb_fall) begin
              r_cnt   <= '0;
              r_shift <= '0;
              r_state <= ST_HEADER;
            end
          end

          ST_HEADER: begin
            if (w_sclk_rise) begin
              r_shift <= w_shift_next[c_hdr_bits-2:0];
              if (r_cnt == c_hdr_last) begin
                r_cnt  <= '0;
                r_addr <= w_shift_next[c_addr_msb:0];
                if (w_shift_next[c_ahi_msb:c_ahi_lsb] != '0) begin
                  r_frame_err <= 1'b1;
                  r_state     <= ST_WAIT_CS;
                end else if (w_shift_next[c_rw_bit]) begin
                  r_tx    <= r_regfile[w_shift_next[c_addr_msb:0]];
                  r_state <= ST_RDATA;
                end else begin
                  r_state <= ST_WDATA;
                end
              end else begin
                r_cnt <= r_cnt + 5'd1;
              end
            end
          end

          ST_WDATA: begin
            if (w_sclk_rise) begin
              r_shift <= w_shift_next[c_hdr_bits-2:0];
              if (r_cnt == c_data_last) begin
                r_cnt       <= '0;
                r_wr_strobe <= 1'b1;
                r_wr_addr   <= r_addr;
                r_wr_data   <= w_shift_next[7:0];
                r_state     <= ST_WAIT_CS;
              end else begin
                r_cnt <= r_cnt + 5'd1;
              end
            end
          end

          ST_RDATA: begin
            // Drive on falls so the controller samples stable data on rises;
            // the fall after the last bit hands the line back.
            if (w_sclk_fall) begin
              if (r_cnt != c_data_done) begin
                r_oe  <= 1'b1;
                r_sdo <= r_tx[7];
                r_tx  <= {r_tx[6:0], 1'b0};
                r_cnt <= r_cnt + 5'd1;
              end else begin
                r_oe    <= 1'b0;
                r_state <= ST_WAIT_CS;
              end
            end
          end

          ST_WAIT_CS: begin
            r_oe <= 1'b0;
            if (w_csb_s && w_sync_ready) begin
              r_state <= ST_IDLE;
            end
          end

          default: begin
            r_oe    <= 1'b0;
            r_state <= ST_WAIT_CS;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register file: SPI write port, registered local read port. A read and a
  // write to the same address in one cycle returns the old contents.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        r_regfile[i] <= 8'h00;
      end
      r_rdata <= 8'h00;
    end else begin
      if (w_wr_en) begin
        r_regfile[r_addr] <= w_shift_next[7:0];
      end
      r_rdata <= r_regfile[reg_addr];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sdio      = r_oe ? r_sdo : 1'bz;
  assign reg_rdata = r_rdata;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != ST_IDLE);

  // sclk level is only consumed through its edge flags.
  logic w_unused;
  assign w_unused = w_sclk_s;

endmodule
`default_nettype wire

// File: doc/spi_adc_target.md
SPI_ADC_TARGET -- requirements
Module: spi_adc_target

Interface
REQ-001 SHALL have parameter CLK_DIV_MIN, default 8, giving the minimum clk/sclk frequency ratio supported (documentation only, not checked).
REQ-002 SHALL have ports: clk  in  1  system clock, all logic on posedge; reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: sclk  in  1  SPI clock, asynchronous to clk; csb  in  1  chip select, active-low, asynchronous.
REQ-004 SHALL have port: sdio  inout  1  3-wire bidirectional data, driven only when the internal oe is high, else high-Z.
REQ-005 SHALL have ports: reg_addr  in  8  local read address; reg_rdata  out  8  local read data.
REQ-006 SHALL have ports: wr_strobe  out  1  one-cycle pulse per completed SPI write; wr_addr  out  8; wr_data  out  8.
REQ-007 SHALL have ports: frame_err  out  1  one-cycle pulse on an aborted or illegal frame; busy  out  1  high while a frame is in progress.

Function
REQ-008 SHALL synchronise sclk, csb and sdio-in through two flops each, and detect sclk rise/fall and csb fall/rise from the synchronised values.
REQ-009 SHALL implement states IDLE, HEADER, WDATA, RDATA and WAIT_CS.
REQ-010 IDLE: a csb fall SHALL clear the bit counter and 16-bit shift register and move to HEADER.
REQ-011 HEADER: each sclk rise SHALL shift sdio in, MSB first; after the 16th rise, bit15 = r/wb, bits14:13 = w1,w0 (ignored), bits12:8 = A12:A8, bits7:0 = address.
REQ-012 If A12:A8 != 0 after the header, the block SHALL pulse frame_err and go to WAIT_CS.
REQ-013 If r/wb = 0, the block SHALL go to WDATA; each sclk rise shifts one data bit, MSB first.
REQ-014 After the 8th WDATA rise, the block SHALL write regfile[addr] <= data, pulse wr_strobe one cycle later with wr_addr/wr_data valid in that same cycle, and go to WAIT_CS.
REQ-015 If r/wb = 1, the block SHALL load an 8-bit tx shift register from regfile[addr] in the cycle the 16th rise is detected and go to RDATA.
REQ-016 RDATA: the first sclk fall SHALL assert oe and drive bit7; each later fall SHALL drive the next lower bit.
REQ-017 RDATA: the fall following the 8th drive SHALL deassert oe and move to WAIT_CS.
REQ-018 sdio output SHALL change only on synchronised sclk falls; input SHALL be sampled only on synchronised sclk rises.
REQ-019 WAIT_CS: sclk edges SHALL be ignored, so bits beyond the frame length have no effect.
REQ-020 A csb rise in any state SHALL deassert oe within 1 clk and return to IDLE.
REQ-021 A csb rise in HEADER, WDATA or RDATA before frame completion SHALL pulse frame_err and SHALL NOT write regfile; a csb rise in WAIT_CS SHALL NOT pulse frame_err.
REQ-022 busy SHALL be high in every state except IDLE.
REQ-023 The regfile SHALL be 256 x 8.
REQ-024 reg_rdata SHALL equal regfile[reg_addr] registered, giving 1-cycle latency.
REQ-025 When a local read and an SPI write target the same address in the same cycle, reg_rdata SHALL return the pre-write value.

Reset
REQ-026 On reset: state = WAIT_CS, oe = 0, wr_strobe = 0, frame_err = 0, busy = 1, wr_addr = 0, wr_data = 0, reg_rdata = 0, all regfile entries = 0x00.
REQ-027 Synchroniser flops SHALL reset to csb = 1, sclk = 0, sdio = 0.
REQ-028 Because the state after reset is WAIT_CS, a frame already in progress when reset asserts SHALL be discarded without frame_err, and no frame is accepted until csb is seen high.

Structure
REQ-029 The header field positions, frame lengths (16/24 bits) and the state encoding SHALL reside in shared package spi_pkg.
REQ-030 Synchronisation plus edge detection SHALL be a sub-module spi_target_sync, instantiated once per input as needed.

Verification
REQ-031 SPI write, header 0x0012, data 0xA5, sclk = clk/8 -> one wr_strobe with wr_addr = 0x12, wr_data = 0xA5; reg_addr = 0x12 gives 0xA5 one cycle later.
REQ-032 After REQ-031, SPI read, header 0x8012 -> sdio driven 1,0,1,0,0,1,0,1 on falls 1..8; oe low after the 9th fall; no wr_strobe.
REQ-033 Write header 0x0112 (A8 = 1) -> frame_err pulse; regfile unchanged; sdio never driven.
REQ-034 csb rises after 20 bits of a write to 0x05 -> frame_err pulse; regfile[0x05] unchanged; busy low within 4 clk.
REQ-035 Reset asserted mid-RDATA with csb held low -> oe low, no frame_err; 8 further sclk pulses ignored; the next full frame after csb high/low succeeds.
REQ-036 SPI write to 0x33 completing in the same cycle that reg_addr = 0x33 is presented -> reg_rdata shows the old value, then the new value one cycle later.
